// File: rtl/cpu_pkg.sv
// cpu_pkg: shared branch encodings, condition-flag indices and EX/MEM FSM states.
package cpu_pkg;
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BGTZ = 3'd3;
    localparam logic [2:0] BR_BLEZ = 3'd4;
    localparam logic [2:0] BR_BLTZ = 3'd5;
    localparam logic [2:0] BR_BGEZ = 3'd6;
    localparam logic [2:0] BR_JR   = 3'd7;

    localparam int COND_EQ  = 0;
    localparam int COND_NE  = 1;
    localparam int COND_GTZ = 2;
    localparam int COND_EQZ = 3;
    localparam int COND_LTZ = 4;
    localparam int COND_OV  = 5;

    typedef enum logic {NORMAL = 1'b0, DRAIN = 1'b1} fsm_t;
endpackage

// File: rtl/branch_resolve.sv
// branch_resolve: decides branch/jr taken from the branch type and EX condition flags.
module branch_resolve
    import cpu_pkg::*;
(
    input  logic [2:0] i_br_type,
    input  logic [4:0] i_cond,
    output logic       o_taken
);
    always_comb begin
        o_taken = (i_br_type == BR_BEQ)  ? i_cond[COND_EQ]  :
                  (i_br_type == BR_BNE)  ? i_cond[COND_NE]  :
                  (i_br_type == BR_BGTZ) ? i_cond[COND_GTZ] :
                  (i_br_type == BR_BLEZ) ? (i_cond[COND_EQZ] | i_cond[COND_LTZ]) :
                  (i_br_type == BR_BLTZ) ? i_cond[COND_LTZ] :
                  (i_br_type == BR_BGEZ) ? ~i_cond[COND_LTZ] :
                  (i_br_type == BR_JR);
    end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline latch with branch/jr resolution, overflow traps and fetch redirect.
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0180,
    parameter int          DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_out,
    input  logic [5:0]  ex_cond,
    input  logic [31:0] ex_rs_val,
    input  logic [31:0] ex_rt_val,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_br_target,
    input  logic [2:0]  ex_br_type,
    input  logic        ex_trap_en,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        stall,
    output logic        mem_valid,
    output logic [31:0] mem_alu_out,
    output logic [31:0] mem_store_data,
    output logic [4:0]  mem_rd,
    output logic        mem_reg_write,
    output logic        mem_mem_read,
    output logic        mem_mem_write,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush_if,
    output logic        trap,
    output logic [31:0] epc
);
    fsm_t       r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic       w_taken, w_eff, w_trap, w_latch, w_redir;

    branch_resolve u_br (
        .i_br_type (ex_br_type),
        .i_cond    (ex_cond[4:0]),
        .o_taken   (w_taken)
    );

    assign w_eff   = ex_valid & (r_state == NORMAL);
    assign w_trap  = w_eff & ex_trap_en & ex_cond[COND_OV];
    assign w_latch = w_eff & ~w_trap;
    assign w_redir = w_trap | (w_eff & w_taken);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!stall && r_state == NORMAL && w_trap) begin
            w_state_nxt = DRAIN;
            w_cnt_nxt   = 4'(DRAIN_CYCLES);
        end else if (!stall && r_state == DRAIN) begin
            w_cnt_nxt   = r_cnt - 4'd1;
            w_state_nxt = (r_cnt == 4'd1) ? NORMAL : DRAIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= NORMAL;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Pulses are recomputed every edge, so a stall always clears them after one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid      <= 1'b0;
            mem_alu_out    <= 32'd0;
            mem_store_data <= 32'd0;
            mem_rd         <= 5'd0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            redirect       <= 1'b0;
            redirect_pc    <= 32'd0;
            flush_if       <= 1'b0;
            trap           <= 1'b0;
            epc            <= 32'd0;
        end else begin
            redirect <= ~stall & w_redir;
            flush_if <= ~stall & w_redir;
            trap     <= ~stall & w_trap;
            if (!stall) begin
                mem_valid     <= w_latch;
                mem_reg_write <= w_latch & ex_reg_write;
                mem_mem_read  <= w_latch & ex_mem_read;
                mem_mem_write <= w_latch & ex_mem_write;
                if (w_latch) begin
                    mem_alu_out    <= ex_alu_out;
                    mem_store_data <= ex_rt_val;
                    mem_rd         <= ex_rd;
                end
                if (w_trap) begin
                    epc         <= ex_pc;
                    redirect_pc <= TRAP_VECTOR;
                end else if (w_redir) begin
                    redirect_pc <= (ex_br_type == BR_JR) ? ex_rs_val : ex_br_target;
                end
            end
        end
    end
endmodule
